// File: rtl/ysyx_25040101_imm_pipe_if.sv
// ysyx_25040101_imm_pipe_if: upstream/downstream handshake bundle for the immediate pipe
interface ysyx_25040101_imm_pipe_if #(parameter int XLEN = 32, parameter int TAG_W = 8);
  logic in_valid;
  logic in_ready;
  logic [31:0] inst;
  logic [6:0] imm_type;
  logic [TAG_W-1:0] in_tag;
  logic flush;
  logic out_valid;
  logic out_ready;
  logic [XLEN-1:0] imm;
  logic [TAG_W-1:0] out_tag;
  logic err;
  modport master(output in_valid, inst, imm_type, in_tag, flush, out_ready,
                 input in_ready, out_valid, imm, out_tag, err);
  modport slave(input in_valid, inst, imm_type, in_tag, flush, out_ready,
                output in_ready, out_valid, imm, out_tag, err);
endinterface

// File: rtl/ysyx_25040101_imm_pipe.sv
// ysyx_25040101_imm_pipe: immediate generator feeding a 2-entry skid buffer toward the EXU
module ysyx_25040101_imm_pipe #(
  parameter int XLEN = 32,
  parameter int TAG_W = 8
) (
  input logic clk,
  input logic rst_n,
  ysyx_25040101_imm_pipe_if.slave bus
);
  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("XLEN must be 32 or 64");
  end
  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [TAG_W-1:0] tag;
    logic err;
  } entry_t;
  // Encoding chosen so out_valid and in_ready are raw state flop bits.
  typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b01, FULL = 2'b11} state_t;
  state_t state, state_nx;
  entry_t main_q, skid_q, new_e;
  logic accept, emit, legal;
  logic [6:0] t;
  logic [31:0] in;
  logic [XLEN-1:0] imm_sel;
  logic unused_bits;
  assign t = bus.imm_type;
  assign in = bus.inst;
  assign unused_bits = ^in[6:0];
  assign legal = $onehot(t);
  assign imm_sel = ({XLEN{t[6]}} & XLEN'($signed(in[31:20])))
                 | ({XLEN{t[5]}} & XLEN'($signed({in[31:25], in[11:7]})))
                 | ({XLEN{t[4]}} & XLEN'($signed({in[31], in[7], in[30:25], in[11:8], 1'b0})))
                 | ({XLEN{t[3]}} & XLEN'($signed({in[31:12], 12'b0})))
                 | ({XLEN{t[2]}} & XLEN'($signed({in[31], in[19:12], in[20], in[30:21], 1'b0})))
                 | ({XLEN{t[1]}} & XLEN'(in[19:15]))
                 | ({XLEN{t[0]}} & XLEN'({XLEN == 64 ? in[25] : 1'b0, in[24:20]}));
  assign new_e = '{imm: legal ? imm_sel : '0, tag: bus.in_tag, err: ~legal};
  assign bus.out_valid = state[0];
  assign bus.in_ready = ~state[1];
  assign bus.imm = main_q.imm;
  assign bus.out_tag = main_q.tag;
  assign bus.err = main_q.err;
  assign accept = bus.in_valid & bus.in_ready;
  assign emit = bus.out_valid & bus.out_ready;
  always_comb begin
    state_nx = state;
    if (bus.flush) state_nx = EMPTY;
    else if (state == EMPTY) state_nx = accept ? ONE : EMPTY;
    else if (state == ONE) state_nx = (accept & ~emit) ? FULL : (~accept & emit) ? EMPTY : ONE;
    else state_nx = emit ? ONE : FULL;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state <= state_nx;
      if (!bus.flush && (state == FULL ? emit : accept & (state == EMPTY | emit)))
        main_q <= state == FULL ? skid_q : new_e;
      if (!bus.flush && state == ONE && accept && !emit) skid_q <= new_e;
    end
  end
endmodule
